// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO-fed, configurable data/stop bits, frames sent back-to-back.
// Optional parity bit is compiled in when `UART_TX_PARITY_EN is defined.
module uart_tx_param #(
  parameter int CLKS_PER_BAUD = 1250,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        parity_odd,
  output logic                        tx_ready,
  output logic                        tx_serial,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BAUD);
  localparam int IW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  logic unused_parity;
  assign unused_parity = parity_odd;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state_q;
  logic [BW-1:0]        baud_q;
  logic [IW-1:0]        bit_q;
  logic                 stop_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 baud_last, stop_last;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign tx_serial  = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign push       = tx_valid && tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign baud_last  = (baud_q == BW'(CLKS_PER_BAUD - 1));
  assign stop_last  = (stop_q == 1'(STOP_BITS - 1));

  // Pop when idle, or on the final stop-bit cycle so the next start bit follows with no gap.
  always_comb begin
    pop = 1'b0;
    if (count_q != '0) begin
      if (state_q == S_IDLE)
        pop = 1'b1;
      else if (state_q == S_STOP && baud_last && stop_last)
        pop = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Parity is fixed for the whole frame using the polarity seen at pop time.
  always_ff @(posedge clk) begin
    if (!nRst)
      par_q <= 1'b0;
    else if (pop)
      par_q <= (^head) ^ parity_odd;
  end
`endif

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          if (pop) begin
            shift_q <= head;
            state_q <= S_START;
            tx_q    <= 1'b0;
          end else begin
            tx_q    <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q  <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q  <= baud_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (!stop_last) begin
              stop_q <= stop_q + 1'b1;
              tx_q   <= 1'b1;
            end else if (pop) begin
              shift_q <= head;
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: frame-level reference model checked every cycle, plus literal frame checks.
module tb_uart_tx_param;
  localparam int CPB   = 4;
  localparam int DB    = 8;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB  = 1 + DB + P + SB;
  localparam int F   = NB * CPB;
  localparam int DB2 = 7;
  localparam int SB2 = 2;
  localparam int NB2 = 1 + DB2 + P + SB2;
  localparam int F2  = NB2 * CPB;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic tx_valid = 1'b0;
  logic parity_odd = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic tx_ready, tx_serial, busy;
  logic [2:0] fifo_count;

  logic tx_valid2 = 1'b0;
  logic [DB2-1:0] tx_data2 = '0;
  logic tx_ready2, tx_serial2, busy2;
  logic [2:0] fifo_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BAUD(CPB), .DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .nRst(nRst), .tx_valid(tx_valid), .tx_data(tx_data), .parity_odd(parity_odd),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_param #(.CLKS_PER_BAUD(CPB), .DATA_BITS(DB2), .STOP_BITS(SB2), .FIFO_DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .nRst(nRst), .tx_valid(tx_valid2), .tx_data(tx_data2), .parity_odd(parity_odd),
    .tx_ready(tx_ready2), .tx_serial(tx_serial2), .busy(busy2), .fifo_count(fifo_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted words and a position inside the current frame.
  logic [DB-1:0] mq[$];
  int            pos = -1;
  logic [DB-1:0] cur_w = '0;
  logic          cur_p = 1'b0;
  int            sz;
  logic          push_m, pop_m;
  logic          exp_tx = 1'b1;
  logic          exp_busy = 1'b0;
  int            exp_cnt = 0;
  logic          model_on = 1'b0;

  function automatic logic frame_bit(input int k, input logic [DB-1:0] w, input logic po);
    if (k == 0) return 1'b0;
    if (k <= DB) return w[k-1];
    if (P == 1 && k == DB + 1) return (^w) ^ po;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!nRst) begin
      mq.delete();
      pos = -1;
    end else begin
      sz     = mq.size();
      push_m = tx_valid && (sz != DEPTH);
      pop_m  = (sz != 0) && (pos < 0 || pos == F - 1);
      if (pop_m) begin
        cur_w = mq.pop_front();
        cur_p = parity_odd;
        pos   = 0;
      end else if (pos == F - 1) begin
        pos = -1;
      end else if (pos >= 0) begin
        pos++;
      end
      if (push_m) mq.push_back(tx_data);
    end
    exp_cnt  = mq.size();
    exp_busy = (pos >= 0);
    exp_tx   = (pos < 0) ? 1'b1 : frame_bit(pos / CPB, cur_w, cur_p);
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("tx_serial", tx_serial, exp_tx);
      check("busy", busy, exp_busy);
      check("fifo_count", fifo_count, exp_cnt);
      check("tx_ready", tx_ready, (exp_cnt != DEPTH));
    end
  end

  task automatic write1(input logic [DB-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic write2(input logic [DB2-1:0] d);
    tx_data2  = d;
    tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
  endtask

  task automatic capture(input bit use2, input int nbits, output logic [15:0] bits, output int bc);
    bits = '1;
    bc   = 0;
    for (int c = 0; c < nbits * CPB + 2 * CPB; c++) begin
      if (use2 ? busy2 : busy) bc++;
      if (c % CPB == 1 && c / CPB < nbits) bits[c / CPB] = use2 ? tx_serial2 : tx_serial;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", (n < budget), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bits;
    int          bc, acc, maxc, first_b, last_b;
    int          e_a5 [11];
    int          e_55 [11];
`ifdef UART_TX_PARITY_EN
    e_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    e_55 = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
`else
    e_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    e_55 = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
`endif

    // Reset held 3 cycles with writes attempted.
    tx_valid  = 1'b1;
    tx_valid2 = 1'b1;
    tx_data   = 8'h5A;
    tx_data2  = 7'h2A;
    @(negedge clk);
    model_on = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx_serial", tx_serial, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_serial2", tx_serial2, 1);
    check("rst_fifo_count2", fifo_count2, 0);
    tx_valid  = 1'b0;
    tx_valid2 = 1'b0;
    nRst      = 1'b1;
    @(negedge clk);
    check("rel_tx_serial", tx_serial, 1);
    check("rel_busy", busy, 0);
    check("rel_fifo_count", fifo_count, 0);
    repeat (3) @(negedge clk);
    check("no_frame_after_reset", busy, 0);

    // Single word 8'hA5.
    parity_odd = 1'b0;
    write1(8'hA5);
    check("a5_count_after_write", fifo_count, 1);
    check("a5_busy_before_pop", busy, 0);
    @(negedge clk);
    check("a5_busy_after_pop", busy, 1);
    check("a5_count_after_pop", fifo_count, 0);
    capture(1'b0, NB, bits, bc);
    for (int k = 0; k < NB; k++) check($sformatf("a5_bit%0d", k), bits[k], e_a5[k]);
    check("a5_busy_cycles", bc, F);

`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
    write1(8'h07);
    @(negedge clk);
    capture(1'b0, NB, bits, bc);
    check("p07_even_parity_bit", bits[9], 1);
    check("p07_even_frame_cycles", bc, 44);
    parity_odd = 1'b1;
    write1(8'h07);
    @(negedge clk);
    capture(1'b0, NB, bits, bc);
    check("p07_odd_parity_bit", bits[9], 0);
    check("p07_odd_frame_cycles", bc, 44);
    parity_odd = 1'b0;
`endif

    // Back-pressure: 6 back-to-back writes into a depth-4 FIFO.
    acc = 0; maxc = 0; first_b = -1; last_b = -1;
    for (int c = 0; c < 6 * F + 20; c++) begin
      if (busy) begin
        if (first_b < 0) first_b = c;
        last_b = c;
      end
      if (fifo_count > maxc) maxc = fifo_count;
      if (c < 6) begin
        tx_data  = 8'(c + 1);
        tx_valid = 1'b1;
        if (tx_ready) acc++;
        if (c == 5) check("bp_ready_low_at_6th", tx_ready, 0);
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("bp_accepted", acc, 5);
    check("bp_max_count", maxc, 4);
    check("bp_busy_span", last_b - first_b + 1, 5 * F);

    // Reset during data bit 3 of 8'hFF with two words queued.
    write1(8'hFF);
    write1(8'h3C);
    write1(8'hC3);
    repeat (16) @(negedge clk);
    check("mid_tx_before_reset", tx_serial, 1);
    check("mid_count_before_reset", fifo_count, 2);
    check("mid_busy_before_reset", busy, 1);
    nRst = 1'b0;
    @(negedge clk);
    check("mid_tx_after_reset", tx_serial, 1);
    check("mid_count_after_reset", fifo_count, 0);
    check("mid_busy_after_reset", busy, 0);
    @(negedge clk);
    nRst = 1'b1;
    bc = 0;
    for (int c = 0; c < 3 * F; c++) begin
      if (busy) bc++;
      @(negedge clk);
    end
    check("mid_no_frame_after_release", bc, 0);

    // Randomised traffic at three load levels, parity polarity changing each cycle.
    for (int seg = 0; seg < 3; seg++) begin
      int rate;
      rate = (seg == 0) ? 5 : (seg == 1) ? 30 : 90;
      for (int c = 0; c < 1000; c++) begin
        tx_valid   = ($urandom_range(0, 99) < rate);
        tx_data    = 8'($urandom);
        parity_odd = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    wait_idle(10 * F);
    parity_odd = 1'b0;
    repeat (2) @(negedge clk);

    // 7 data bits, 2 stop bits, 7'h55.
    write2(7'h55);
    @(negedge clk);
    check("w7_busy_after_pop", busy2, 1);
    capture(1'b1, NB2, bits, bc);
    for (int k = 0; k < NB2; k++) check($sformatf("w7_bit%0d", k), bits[k], e_55[k]);
    check("w7_busy_cycles", bc, F2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised, buffered UART transmitter serialising words from a small internal FIFO onto `tx_serial`. It is the next-generation transmit path for the team's serial link and supersedes the fixed 8N1, single-byte transmitter. It adds configurable data width, stop-bit count and FIFO depth, plus an optional parity bit. Frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface
- `CLKS_PER_BAUD`, 1250: clock cycles per bit; must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1  system clock.
- `nRst`  in  1  reset; synchronous, active-low.
- `tx_valid`  in  1  write strobe; a write occurs when `tx_valid && tx_ready` at a rising edge.
- `tx_data`  in  DATA_BITS  word to enqueue.
- `parity_odd`  in  1  selects parity: 1 = odd, 0 = even. Used only with the parity macro defined; ignored otherwise.
- `tx_ready`  out  1  FIFO not full; combinational from the registered count.
- `tx_serial`  out  1  serial line; idle high; registered.
- `busy`  out  1  high while the FSM is not in IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current number of FIFO entries.

## Operation
- FIFO: circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo depth.
  - A write while full is ignored; the data is dropped and state is unchanged.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: `tx_serial` = 1. If `fifo_count` ≠ 0, pop the head into the shift register, go to START and drive 0.
  - START: lasts 1 bit time, then DATA.
  - DATA: sends DATA_BITS bits LSB first, 1 bit time each. Bit index counts 0..DATA_BITS-1.
  - After the last data bit: go to PARITY if the macro is defined, else STOP.
  - PARITY: 1 bit time. Bit value is XOR of data bits, XOR `parity_odd`.
  - STOP: drives 1 for STOP_BITS bit times.
  - Leaving STOP with FIFO non-empty: pop and go directly to START, with no idle cycle. Otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BAUD-1 and resets on every bit boundary. Each bit is exactly CLKS_PER_BAUD cycles.
- `parity_odd` is sampled when the word is popped and held for that frame.
- `tx_data` is captured at write time; later changes do not affect queued words.

## Timing
- Values while `nRst` = 0 and on the edge after it is released:
  - `tx_serial` = 1, `busy` = 0, `tx_ready` = 1, `fifo_count` = 0.
  - FSM = IDLE, pointers = 0, baud counter = 0.
- Reset mid-frame aborts the frame. `tx_serial` returns high at the reset edge and FIFO contents are discarded.
- Write at edge E with FSM idle and FIFO empty:
  - `fifo_count` = 1 after E.
  - Pop at E+1; `tx_serial` = 0 and `busy` = 1 after E+1.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BAUD cycles, where P = 1 with the macro, else 0.
- `busy` falls F cycles after the start edge if no further data is queued.
- `tx_ready` falls in the cycle after the write that makes `fifo_count` = FIFO_DEPTH.
- `tx_ready` rises in the cycle after the next pop.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state is compiled in and one parity bit follows the data bits. P = 1.
- Undefined: no PARITY state, `parity_odd` is ignored, frame is start + data + stop. P = 0.

## Test plan
All scenarios use CLKS_PER_BAUD = 4 and DATA_BITS = 8 unless stated.
- Reset: hold `nRst` low 3 cycles with `tx_valid` = 1 → `tx_serial` = 1, `busy` = 0, `fifo_count` = 0, `tx_ready` = 1; no frame starts.
- Single word, parity off: write 8'hA5 →
  - line = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - `busy` high for exactly 40 cycles.
- Parity on, `UART_TX_PARITY_EN` defined, 8'h07:
  - even (`parity_odd` = 0) → parity bit 1;
  - odd (`parity_odd` = 1) → parity bit 0;
  - frame = 44 cycles.
- Back-pressure, FIFO_DEPTH = 4:
  - drive 6 back-to-back writes 8'h01..8'h06 → 5 accepted;
  - `fifo_count` reaches 4 and `tx_ready` drops, so 8'h06 is dropped;
  - frames 01..05 go out with no idle gaps between stop and start bits.
- Reset mid-frame: pull `nRst` low during data bit 3 of 8'hFF with 2 words queued → `tx_serial` = 1 next edge, `fifo_count` = 0, and no frame follows the release.
- Width/stop variant: DATA_BITS = 7, STOP_BITS = 2, write 7'h55 →
  - bits 0,1,0,1,0,1,0,1,1,1, each 4 cycles;
  - 40-cycle frame.
